// File: rtl/pr_arbiter.sv
// 8-way arbiter with registered one-hot grant, selectable fixed-priority or
// round-robin selection, and a bounded hold time per owner.
module pr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 15,
  parameter int CW       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  input  logic         mode,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_id,
  output logic         busy,
  output logic         idle,
  output logic         timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_SAT = {CW{1'b1}};

  logic [1:0]    state_reg, state_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [2:0]    gnt_id_reg, gnt_id_next;
  logic          busy_reg, busy_next;
  logic          idle_reg, idle_next;
  logic          timeout_reg, timeout_next;
  logic [CW-1:0] hold_reg, hold_next;
  logic [2:0]    rr_ptr_reg, rr_ptr_next;

  logic [2:0]    fp_id;
  logic [N-1:0]  rr_rot;
  logic [2:0]    rr_off;
  logic [2:0]    rr_id;
  logic [2:0]    win_id;
  logic          owner_req;

  // Fixed priority: the highest set bit wins, so the last hit in an ascending scan is kept.
  always_comb begin
    fp_id = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fp_id = 3'(i);
    end
  end

  // Round-robin: rr_rot[j] is the requester j+1 positions below rr_ptr (mod 8).
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rr_rot[gi] = req[rr_ptr_reg - 3'(gi + 1)];
    end
  endgenerate

  always_comb begin
    rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rr_rot[i]) rr_off = 3'(i);
    end
  end

  assign rr_id     = rr_ptr_reg - rr_off - 3'd1;
  assign win_id    = mode ? rr_id : fp_id;
  assign owner_req = req[gnt_id_reg];

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    busy_next    = busy_reg;
    idle_next    = idle_reg;
    timeout_next = 1'b0;
    hold_next    = hold_reg;
    rr_ptr_next  = rr_ptr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req != '0) begin
          state_next  = ST_GRANT;
          gnt_next    = N'(1) << win_id;
          gnt_id_next = win_id;
          busy_next   = 1'b1;
          idle_next   = 1'b0;
          hold_next   = CW'(1);
          if (mode) rr_ptr_next = win_id;
        end else begin
          idle_next = 1'b1;
        end
      end

      ST_GRANT: begin
        idle_next = 1'b0;
        // done outranks the hold limit, so a finishing owner never sees a timeout pulse.
        if (done || !owner_req || hold_reg == HOLD_MAX) begin
          state_next   = ST_RELEASE;
          gnt_next     = '0;
          busy_next    = 1'b0;
          hold_next    = '0;
          timeout_next = !done && owner_req;
        end else if (hold_reg != HOLD_SAT) begin
          hold_next = hold_reg + CW'(1);
        end
      end

      ST_RELEASE: begin
        state_next = ST_IDLE;
        idle_next  = (req == '0);
      end

      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
        idle_next  = 1'b1;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      busy_reg    <= 1'b0;
      idle_reg    <= 1'b1;
      timeout_reg <= 1'b0;
      hold_reg    <= '0;
      rr_ptr_reg  <= 3'd7;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      idle_reg    <= idle_next;
      timeout_reg <= timeout_next;
      hold_reg    <= hold_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = busy_reg;
  assign idle    = idle_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_pr_arbiter.sv
// Self-checking bench for pr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pr_arbiter;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       idle;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: who owns the resource and for how long.
  int m_owner;
  int m_held;
  int m_ptr;
  int m_last;
  bit m_dead;
  bit m_idle;
  bit m_to;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       idle;
    logic       to;
  } vec_t;

  vec_t vecs[8];

  pr_arbiter #(.N(8), .MAX_HOLD(MAX_HOLD), .CW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .mode   (mode),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .idle   (idle),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pack(input logic [7:0] g, input logic [2:0] id,
                                       input logic b, input logic i, input logic t);
    return {g, id, b, i, t};
  endfunction

  function automatic logic [13:0] dut_pack();
    return pack(gnt, gnt_id, busy, idle, timeout);
  endfunction

  function automatic logic [13:0] model_pack();
    logic [7:0] g;
    g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    return pack(g, 3'(m_last), m_owner >= 0, m_idle, m_to);
  endfunction

  task automatic expect_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input bit m, input int ptr);
    if (!m) begin
      for (int k = 7; k >= 0; k--) if (r[k]) return k;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (ptr - k + 8) % 8;
        if (r[idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 7;
    m_last  = 0;
    m_dead  = 1'b0;
    m_idle  = 1'b1;
    m_to    = 1'b0;
  endtask

  task automatic model_release(input bit forced);
    m_owner = -1;
    m_dead  = 1'b1;
    m_idle  = 1'b0;
    m_to    = forced;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, input logic m);
    int w;
    if (m_dead) begin
      m_dead = 1'b0;
      m_to   = 1'b0;
      m_idle = (r == 8'h00);
    end else if (m_owner >= 0) begin
      m_to = 1'b0;
      if (d) model_release(1'b0);
      else if (!r[m_owner]) model_release(1'b0);
      else if (m_held >= MAX_HOLD) model_release(1'b1);
      else m_held++;
    end else begin
      m_to = 1'b0;
      w = pick(r, m, m_ptr);
      if (w < 0) begin
        m_idle = 1'b1;
      end else begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
        m_idle  = 1'b0;
        if (m) m_ptr = w;
      end
    end
  endtask

  // Drive inputs just after an edge, advance one clock, then sample 1 ns later.
  task automatic tick(input logic [7:0] r, input logic d, input logic m);
    req  = r;
    done = d;
    mode = m;
    @(posedge clk);
    model_step(r, d, m);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int guard;
    logic [7:0] r;
    logic d;
    logic m;
    logic prev_busy;
    int exp_ids[9];

    //            req    done  mode  gnt    id    busy  idle  to
    vecs[0] = '{8'h26, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h06, 1'b1, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h06, 1'b0, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h06, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h06, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 1'b0};

    // Reset state
    do_reset();
    expect_eq("reset_state", int'(dut_pack()), int'(pack(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)));

    // Vector table: fixed priority, two dead cycles, withdrawal, round-robin wrap
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].req, vecs[i].done, vecs[i].mode);
      $display("vec %0d req=%h done=%0d mode=%0d -> gnt=%h id=%0d busy=%0d idle=%0d to=%0d",
               i, vecs[i].req, vecs[i].done, vecs[i].mode, gnt, gnt_id, busy, idle, timeout);
      expect_eq($sformatf("vec%0d", i), int'(dut_pack()),
                int'(pack(vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].idle, vecs[i].to)));
    end

    // Round-robin: park rr_ptr at 0, then all requests cycle 7..0,7
    do_reset();
    tick(8'h01, 1'b0, 1'b1);
    expect_eq("rr_prime_id", int'(gnt_id), 0);
    tick(8'hFF, 1'b1, 1'b1);
    tick(8'hFF, 1'b0, 1'b1);
    exp_ids = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    for (int i = 0; i < 9; i++) begin
      tick(8'hFF, 1'b0, 1'b1);
      $display("rr grant %0d id=%0d gnt=%h", i, gnt_id, gnt);
      expect_eq($sformatf("rr_seq%0d", i), int'({gnt, gnt_id}),
                int'({8'(1 << exp_ids[i]), 3'(exp_ids[i])}));
      tick(8'hFF, 1'b1, 1'b1);
      tick(8'hFF, 1'b0, 1'b1);
    end

    // Timeout: single requester held with no done
    do_reset();
    tick(8'h01, 1'b0, 1'b0);
    cnt = 0;
    guard = 0;
    while (gnt == 8'h01 && guard < 40) begin
      cnt++;
      guard++;
      tick(8'h01, 1'b0, 1'b0);
    end
    $display("timeout run: gnt held %0d cycles, timeout=%0d", cnt, timeout);
    expect_eq("to_hold_cycles", cnt, MAX_HOLD);
    expect_eq("to_pulse", int'({gnt, busy, timeout}), int'({8'h00, 1'b0, 1'b1}));
    tick(8'h01, 1'b0, 1'b0);
    expect_eq("to_pulse_clear", int'({gnt, timeout}), int'({8'h00, 1'b0}));
    tick(8'h01, 1'b0, 1'b0);
    expect_eq("to_regrant", int'({gnt, gnt_id}), int'({8'h01, 3'd0}));

    // done in the same cycle the hold limit is reached
    do_reset();
    tick(8'h01, 1'b0, 1'b0);
    repeat (MAX_HOLD - 1) tick(8'h01, 1'b0, 1'b0);
    expect_eq("sim_still_granted", int'(gnt), 8'h01);
    tick(8'h01, 1'b1, 1'b0);
    $display("done at hold limit: gnt=%h timeout=%0d", gnt, timeout);
    expect_eq("sim_no_timeout", int'({gnt, timeout}), int'({8'h00, 1'b0}));

    // Owner withdraws while a higher requester arrives
    do_reset();
    tick(8'h02, 1'b0, 1'b0);
    tick(8'h08, 1'b0, 1'b0);
    expect_eq("swap_release", int'({gnt, busy, timeout}), int'({8'h00, 1'b0, 1'b0}));
    tick(8'h08, 1'b0, 1'b0);
    expect_eq("swap_dead", int'(gnt), 8'h00);
    tick(8'h08, 1'b0, 1'b0);
    $display("swap: new owner id=%0d", gnt_id);
    expect_eq("swap_grant", int'({gnt, gnt_id}), int'({8'h08, 3'd3}));

    // Withdrawal after three granted cycles
    do_reset();
    repeat (3) tick(8'h10, 1'b0, 1'b0);
    expect_eq("wd_granted", int'(gnt), 8'h10);
    tick(8'h00, 1'b0, 1'b0);
    expect_eq("wd_release", int'({busy, timeout, idle}), int'({1'b0, 1'b0, 1'b0}));
    tick(8'h00, 1'b0, 1'b0);
    expect_eq("wd_idle", int'({idle, gnt_id}), int'({1'b1, 3'd4}));

    // Asynchronous reset in the middle of a grant
    do_reset();
    tick(8'h20, 1'b0, 1'b0);
    tick(8'h20, 1'b0, 1'b0);
    expect_eq("arst_pre", int'(gnt), 8'h20);
    #2;
    rst = 1'b1;
    #2;
    $display("async reset mid-grant: gnt=%h busy=%0d idle=%0d to=%0d", gnt, busy, idle, timeout);
    expect_eq("arst_now", int'({gnt, busy, idle, timeout}), int'({8'h00, 1'b0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(8'h00, 1'b0, 1'b0);
    expect_eq("arst_after", int'({gnt, idle}), int'({8'h00, 1'b1}));

    // Randomized traffic against the behavioural model
    do_reset();
    r = 8'h00;
    m = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) r = 8'($urandom()) & 8'($urandom());
      if ($urandom_range(31) == 0) r = 8'h00;
      d = ($urandom_range(15) == 0);
      if ($urandom_range(63) == 0) m = ~m;
      tick(r, d, m);
      if (busy && !prev_busy)
        $display("rand cycle %0d: grant id=%0d mode=%0d req=%h", i, gnt_id, m, r);
      prev_busy = busy;
      expect_eq($sformatf("rand%0d", i), int'(dut_pack()), int'(model_pack()));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pr_arbiter.md
Name: pr_arbiter

Overview:
- Sequential 8-way arbiter built on the fixed-priority encoding rule: bit 7 is highest and bit 0 is lowest.
- Shares one downstream resource between 8 requesters.
- Grants are registered, one-hot and held until the owner signals done, drops its request, or hits a hold timeout.
- An optional round-robin mode rotates priority so the last owner moves to the bottom.

Parameters:
N, 8, number of requesters; fixed at 8 for this revision.
MAX_HOLD, 15, maximum consecutive GRANT cycles before forced release; legal range 1..255.
CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  8  request vector; req[k] high while requester k wants the resource
done  input  1  current owner finished; only meaningful in GRANT
mode  input  1  0 = fixed priority (7 highest), 1 = round-robin; sampled in IDLE only
gnt  output  8  one-hot registered grant; all-zero when no owner
gnt_id  output  3  binary index of the current owner; valid when busy=1
busy  output  1  high while in GRANT
idle  output  1  registered; high when in IDLE and no request was pending on the previous edge
timeout  output  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, idle=1, rr_ptr=7, hold_cnt=0. Applies immediately, including mid-grant; no done handshake is required on exit.
- States: IDLE, GRANT, RELEASE.
- IDLE, req==0: stay in IDLE; idle=1 on the next edge.
- IDLE, req!=0: on the next edge select winner w, set gnt=1<<w, gnt_id=w, busy=1, idle=0, hold_cnt=1, go to GRANT. Request-to-grant latency is 1 cycle.
- Winner selection, mode=0: highest set bit of req (the encoder rule).
- Winner selection, mode=1: search downward starting at rr_ptr-1 (mod 8), wrapping 0 to 7; the first set bit wins. rr_ptr is then updated to w at grant time.
- Consequence in mode=1: with all requests asserted, grants cycle 7,6,5,...,0,7.
- GRANT: gnt, gnt_id and the rest of the req vector are ignored except req[gnt_id]; hold_cnt increments each cycle. Exit conditions, evaluated each edge in priority order:
  - (a) done=1: go to RELEASE, timeout=0.
  - (b) req[gnt_id]=0 (requester withdrew): go to RELEASE, timeout=0.
  - (c) hold_cnt==MAX_HOLD: go to RELEASE, timeout=1 for that one cycle.
  - done and the timeout condition in the same cycle resolve as (a); no timeout pulse.
- RELEASE: gnt=0, busy=0 for exactly 1 cycle (dead cycle that guarantees a break between owners), timeout cleared on the following edge; then go to IDLE. No new grant can be issued during RELEASE.
- Owner-to-owner turnaround: last GRANT cycle, then RELEASE, then IDLE, then GRANT. Minimum 2 cycles with gnt=0 between consecutive grants.
- A requester still asserting after a timeout competes normally. In mode=0 it may win again if it is still highest; in mode=1 it is deprioritised.
- mode changes outside IDLE take effect at the next IDLE evaluation; rr_ptr is preserved across mode changes.
- Outputs are all registered; no combinational path from req to gnt.
- Invariants:
  - gnt is always 0 or one-hot.
  - busy == (gnt != 0).
  - gnt_id is held at the last owner when not busy.
- hold_cnt saturates; it never wraps inside GRANT.

Test Plan:
- Reset: assert rst mid-GRANT with gnt=8'h20 -> gnt=0, busy=0, idle=1, timeout=0 asynchronously; after release, req=0 gives no grant.
- Fixed priority: mode=0, req=8'b0010_0110 held in IDLE -> one cycle later gnt=8'h20, gnt_id=5; done pulse -> RELEASE; next grant gnt=8'h04, gnt_id=2, exactly 2 zero-gnt cycles between grants.
- Round-robin: mode=1, req=8'hFF held, done pulsed each grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7.
- Timeout: MAX_HOLD=15, req=8'h01 held, done=0 -> gnt=8'h01 for exactly 15 cycles, then timeout=1 for 1 cycle with gnt=0; re-grant to 0 two cycles later.
- Simultaneous events: done=1 in the same cycle hold_cnt reaches MAX_HOLD -> no timeout pulse. Owner drops req while a higher req arrives -> release, then the higher requester is granted.
- Withdrawal: req=8'h10 granted, req[4] deasserted after 3 cycles -> RELEASE on the next edge, busy=0, timeout=0, idle=1 two cycles later if req=0.
